// File: rtl/circuit2_seq.sv
// circuit2_seq: multi-cycle, resource-shared Circuit2 sequencer.
// Computes x and z from operands a, b, c using a single shared
// adder/subtractor and a single comparator, stepped by a six-state FSM.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, sampled only while idle
//   a, b, c    unsigned operands, latched on the accepting edge
//   busy       high while an operation is in flight
//   done       one-cycle pulse in the cycle after x/z update
//   x, z       registered results, held until the next completed operation
module circuit2_seq #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] x,
  output logic [DATAWIDTH-1:0] z
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALC_D  = 3'd1,
    CALC_E  = 3'd2,
    CALC_F  = 3'd3,
    COMPARE = 3'd4,
    WRITE   = 3'd5
  } state_t;

  state_t               state, state_n;
  logic [DATAWIDTH-1:0] op_a, op_b, op_c;
  logic [DATAWIDTH-1:0] op_a_n, op_b_n, op_c_n;
  logic [DATAWIDTH-1:0] d, e, f, g, h;
  logic [DATAWIDTH-1:0] d_n, e_n, f_n, g_n, h_n;
  logic                 lt_r, eq_r, lt_r_n, eq_r_n;
  logic                 busy_n, done_n;
  logic [DATAWIDTH-1:0] x_n, z_n;

  // Shared adder/subtractor: subtraction is a + ~b + 1 through the same adder.
  logic                 sub_c;
  logic [DATAWIDTH-1:0] add_b_c, add_b_eff_c, sum_c;
  assign sub_c       = (state == CALC_F);
  assign add_b_c     = (state == CALC_E) ? op_c : op_b;
  assign add_b_eff_c = sub_c ? ~add_b_c : add_b_c;
  assign sum_c       = op_a + add_b_eff_c + DATAWIDTH'(sub_c);

  // Single comparator and the select logic fed from its live outputs.
  logic                 lt_c, eq_c;
  logic [DATAWIDTH-1:0] g_c, h_c;
  assign lt_c = (d < e);
  assign eq_c = (d == e);
  assign g_c  = lt_c ? e : d;
  assign h_c  = eq_c ? f : g_c;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      op_c  <= '0;
      d     <= '0;
      e     <= '0;
      f     <= '0;
      g     <= '0;
      h     <= '0;
      lt_r  <= 1'b0;
      eq_r  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      x     <= '0;
      z     <= '0;
    end else begin
      state <= state_n;
      op_a  <= op_a_n;
      op_b  <= op_b_n;
      op_c  <= op_c_n;
      d     <= d_n;
      e     <= e_n;
      f     <= f_n;
      g     <= g_n;
      h     <= h_n;
      lt_r  <= lt_r_n;
      eq_r  <= eq_r_n;
      busy  <= busy_n;
      done  <= done_n;
      x     <= x_n;
      z     <= z_n;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_n = state;
    op_a_n  = op_a;
    op_b_n  = op_b;
    op_c_n  = op_c;
    d_n     = d;
    e_n     = e;
    f_n     = f;
    g_n     = g;
    h_n     = h;
    lt_r_n  = lt_r;
    eq_r_n  = eq_r;
    done_n  = 1'b0;
    x_n     = x;
    z_n     = z;

    case (state)
      IDLE: begin
        if (start) begin
          op_a_n  = a;
          op_b_n  = b;
          op_c_n  = c;
          state_n = CALC_D;
        end
      end
      CALC_D: begin
        d_n     = sum_c;
        state_n = CALC_E;
      end
      CALC_E: begin
        e_n     = sum_c;
        state_n = CALC_F;
      end
      CALC_F: begin
        f_n     = sum_c;
        state_n = COMPARE;
      end
      COMPARE: begin
        lt_r_n  = lt_c;
        eq_r_n  = eq_c;
        g_n     = g_c;
        h_n     = h_c;
        state_n = WRITE;
      end
      WRITE: begin
        x_n     = lt_r ? {g[DATAWIDTH-2:0], 1'b0} : g;
        z_n     = eq_r ? {1'b0, h[DATAWIDTH-1:1]} : h;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_circuit2_seq.sv
// tb_circuit2_seq: directed and randomized checks of circuit2_seq against
// an arithmetic reference of the Circuit2 function and its cycle timing.
module tb_circuit2_seq;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] a, b, c;
  logic          busy, done;
  logic [DW-1:0] x, z;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_x = '0;
  logic [DW-1:0] exp_z = '0;

  circuit2_seq #(.DATAWIDTH(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .busy  (busy),
    .done  (done),
    .x     (x),
    .z     (z)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: the Circuit2 function from its arithmetic definition.
  task automatic model(input logic [DW-1:0] ia, ib, ic, output logic [DW-1:0] ox, oz);
    logic [DW-1:0] dd, ee, hh;
    dd = ia + ib;
    ee = ia + ic;
    if (dd < ee) ox = ee * 2;
    else         ox = dd;
    if (dd == ee) begin
      hh = ia - ib;
      oz = hh / 2;
    end else begin
      oz = (dd < ee) ? ee : dd;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, DW'(busy), DW'(0));
    chk({tag, "_done"}, DW'(done), DW'(0));
    chk({tag, "_x"}, x, exp_x);
    chk({tag, "_z"}, z, exp_z);
  endtask

  // One operation: accept at edge T, verify busy/done/hold over T..T+4,
  // results at T+5. scramble toggles start and operands while busy.
  // On return we sit in the done cycle with start = keep_start.
  task automatic run_op(input string tag, input logic [DW-1:0] ia, ib, ic,
                        input bit scramble, input bit keep_start);
    logic [DW-1:0] mx, mz;
    model(ia, ib, ic, mx, mz);
    a = ia; b = ib; c = ic; start = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      chk({tag, "_busy"}, DW'(busy), DW'(1));
      chk({tag, "_nodone"}, DW'(done), DW'(0));
      chk({tag, "_xhold"}, x, exp_x);
      chk({tag, "_zhold"}, z, exp_z);
      if (scramble) begin
        a = $urandom; b = $urandom; c = $urandom;
        start = 1'($urandom_range(0, 1));
      end else begin
        start = keep_start;
      end
      step();
    end
    exp_x = mx;
    exp_z = mz;
    chk({tag, "_done"}, DW'(done), DW'(1));
    chk({tag, "_busy_end"}, DW'(busy), DW'(0));
    chk({tag, "_x"}, x, exp_x);
    chk({tag, "_z"}, z, exp_z);
    start = keep_start;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;

    // Reset held for two cycles, then quiet idle.
    step();
    chk_idle_outputs("rst1");
    step();
    chk_idle_outputs("rst2");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle_outputs("idle_quiet");
    end

    // Directed vectors.
    run_op("lt_case", 32'd5, 32'd3, 32'd10, 1'b0, 1'b0);
    chk({"lt_x_const"}, x, 32'd30);
    chk({"lt_z_const"}, z, 32'd15);
    step();
    chk_idle_outputs("lt_after");

    run_op("eq_case", 32'd5, 32'd7, 32'd7, 1'b0, 1'b0);
    chk("eq_x_const", x, 32'd12);
    chk("eq_z_const", z, 32'h7FFF_FFFF);
    step();

    run_op("wrap", 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b0);
    chk("wrap_x_const", x, 32'hFFFF_FFFE);
    chk("wrap_z_const", z, 32'hFFFF_FFFF);
    step();

    // Start pulses and operand changes while busy are ignored.
    run_op("ignore", 32'd10, 32'd9, 32'd1, 1'b1, 1'b0);
    chk("ign_x_const", x, 32'd19);
    chk("ign_z_const", z, 32'd19);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle_outputs("ign_hold");
    end

    // Reset mid-operation after an earlier result.
    run_op("pre_abort", 32'd5, 32'd3, 32'd10, 1'b0, 1'b0);
    step();
    a = 32'd1; b = 32'd2; c = 32'd3; start = 1'b1;
    step();                          // edge T
    start = 1'b0;
    step();                          // T+1
    step();                          // T+2
    chk("abort_busy_pre", DW'(busy), DW'(1));
    rst = 1'b1;
    step();                          // T+3 with rst
    rst = 1'b0;
    exp_x = '0;
    exp_z = '0;
    chk_idle_outputs("abort");
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle_outputs("abort_quiet");
    end
    run_op("post_abort", 32'd5, 32'd7, 32'd7, 1'b0, 1'b0);
    step();

    // Reset wins over start on the same edge.
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    exp_x = '0;
    exp_z = '0;
    chk_idle_outputs("rst_prio");

    // Start held high: back-to-back issue every 6 cycles.
    for (int i = 0; i < 4; i++)
      run_op("b2b", $urandom, $urandom, $urandom, 1'b0, (i != 3));
    step();
    chk_idle_outputs("b2b_end");

    // Randomized operations, with and without scrambling and gaps.
    for (int i = 0; i < 30; i++) begin
      logic [DW-1:0] ra, rb, rc;
      ra = $urandom; rb = $urandom; rc = $urandom;
      case (i % 4)
        1: rc = rb;                          // force d == e
        2: ra = 32'hFFFF_FFFF - (ra & 32'hF);
        default: ;
      endcase
      run_op("rand", ra, rb, rc, 1'($urandom_range(0, 1)), 1'b0);
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        step();
        chk_idle_outputs("rand_gap");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/circuit2_seq.md
# circuit2_seq

Multi-cycle, resource-shared sequencer that computes the Circuit2 result pair (x, z) from three operands using one shared adder/subtractor and one comparator. Replaces the fully parallel datapath where area matters more than throughput. An FSM sequences the shared units through five compute cycles, guarded by a start/busy/done handshake. Results sit in output registers and hold until the next completed operation.

## Interface
- DATAWIDTH, 32, operand and result width in bits
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  DATAWIDTH  operand a, unsigned
- b  input  DATAWIDTH  operand b, unsigned
- c  input  DATAWIDTH  operand c, unsigned
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when x and z are updated
- x  output  DATAWIDTH  registered result x
- z  output  DATAWIDTH  registered result z

## Operation
- Function (all arithmetic unsigned, modulo 2^DATAWIDTH, carries/borrows discarded):
  - d = a+b; e = a+c; f = a−b
  - lt = (d<e); eq = (d==e)
  - g = lt ? e : d; h = eq ? f : g
  - x = g << lt (shift by 0 or 1); z = h >> eq (logical shift by 0 or 1)
- Resources: exactly one DATAWIDTH adder/subtractor (operand muxes plus add/sub select) and one comparator producing lt and eq. No second adder.
- Internal registers: opA, opB, opC, d, e, f, g, h, ltR, eqR.
- FSM states and transitions:
  - IDLE: if start=1, latch a/b/c into opA/opB/opC and go to CALC_D; otherwise stay.
  - CALC_D: d <= opA+opB; go to CALC_E.
  - CALC_E: e <= opA+opC; go to CALC_F.
  - CALC_F: f <= opA−opB; go to COMPARE.
  - COMPARE: ltR/eqR <= compare(d,e); g and h are computed combinationally from the live compare and registered; go to WRITE.
  - WRITE: x <= g<<ltR; z <= h>>eqR; done <= 1; go to IDLE.
- busy = 1 in every state except IDLE (registered or decoded from state; must match the Timing section).
- start outside IDLE is ignored. It is not queued and it does not alter latched operands.
- a/b/c are sampled only on the accepting edge. Later changes do not affect the in-flight operation.
- x and z change only in WRITE and otherwise hold their value.

## Timing
- Reset: state=IDLE, busy=0, done=0, x=0, z=0. All internal registers are cleared to 0.
- Reset mid-operation: the next edge with rst=1 aborts the operation. No done pulse is issued, and x/z are forced to 0.
- Let T be the edge where IDLE samples start=1.
  - busy=1 in the cycles after edges T through T+4.
  - x/z are updated at edge T+5. done=1 for exactly the cycle after T+5, and busy=0 in that same cycle.
- Latency: 5 cycles from start acceptance to valid results.
- Back-to-back: start held high through the done cycle is accepted at edge T+6. Minimum issue interval is 6 cycles.
- start=1 held continuously yields a done pulse every 6 cycles.
- rst has priority over start on the same edge.

## Test plan
- Reset: assert rst for 2 cycles, then hold start=0 → busy=0, done=0, x=0, z=0 and all remain stable.
- a=5, b=3, c=10 → d=8, e=15, lt=1, eq=0, g=15, h=15 → x=30, z=15. done pulses exactly 5 edges after acceptance.
- a=5, b=7, c=7 → d=e=12, lt=0, eq=1, g=12, f=0xFFFFFFFE → x=12, z=0x7FFFFFFF.
- Wrap-around: a=0xFFFFFFFF, b=2, c=0 → d=1, e=0xFFFFFFFF, lt=1 → x=0xFFFFFFFE, z=0xFFFFFFFF.
- Ignore/hold: start with a=10, b=9, c=1, then pulse start and change a/b/c while busy → single result x=19, z=19. Only one done pulse; x/z are held afterward.
- Reset mid-op: after an earlier result x=30, z=15, start a new operation and assert rst at edge T+3 → no done pulse, x=0, z=0, busy=0. A new start afterward completes normally.
